// File: rtl/instr_cache_sa.sv
// Set-associative instruction cache with an integrated block refill controller.
// Hits return the addressed word in the same cycle. A miss fetches the whole
// block beat by beat into a line buffer, which is then written into the victim
// way of the set. A flush invalidates every line in a single cycle. If a refill
// is in flight, the flush is deferred and applied when that refill completes.
module instr_cache_sa #(
   parameter int ADDR_WIDTH     = 64,
   parameter int WORD_SIZE      = 32,
   parameter int WORD_COUNT     = 16,
   parameter int SET_COUNT      = 64,
   parameter int WAY_COUNT      = 2,
   parameter int MEM_DATA_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      arstn,
   input  logic [ADDR_WIDTH-1:0]     i_instr_addr,
   input  logic                      i_req,
   input  logic                      i_flush,
   output logic [WORD_SIZE-1:0]      o_instr,
   output logic                      o_hit,
   output logic                      o_stall,
   output logic                      o_instr_addr_ma,
   output logic                      o_mem_req,
   output logic [ADDR_WIDTH-1:0]     o_mem_addr,
   input  logic                      i_mem_gnt,
   input  logic                      i_mem_valid,
   input  logic [MEM_DATA_WIDTH-1:0] i_mem_data
);

   localparam int BLOCK_WIDTH = WORD_COUNT * WORD_SIZE;
   localparam int BEATS       = BLOCK_WIDTH / MEM_DATA_WIDTH;
   localparam int OFF_W       = $clog2(WORD_COUNT);
   localparam int IDX_W       = $clog2(SET_COUNT);
   localparam int IDX_LSB     = 2 + OFF_W;
   localparam int TAG_LSB     = IDX_LSB + IDX_W;
   localparam int TAG_W       = ADDR_WIDTH - TAG_LSB;
   localparam int WAY_W       = (WAY_COUNT > 1) ? $clog2(WAY_COUNT) : 1;
   localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RECV = 2'd2,
      S_FILL = 2'd3
   } state_t;

   // Control state
   state_t                  state_q, state_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic                    flush_pend_q, flush_pend_d;
   logic [ADDR_WIDTH-1:0]   blk_addr_q, blk_addr_d;

   // Storage: valid bits and victim pointers are reset; tag and data arrays are not
   logic [WAY_COUNT-1:0]    valid_q [SET_COUNT];
   logic [WAY_W-1:0]        vptr_q  [SET_COUNT];
   logic [TAG_W-1:0]        tag_q   [SET_COUNT][WAY_COUNT];
   logic [BLOCK_WIDTH-1:0]  data_q  [SET_COUNT][WAY_COUNT];
   logic [BLOCK_WIDTH-1:0]  buf_q;

   // Lookup and fill-side decode
   logic                    ma_s;
   logic [IDX_W-1:0]        idx_s;
   logic [TAG_W-1:0]        tag_s;
   logic [OFF_W-1:0]        off_s;
   logic [WAY_COUNT-1:0]    match_s;
   logic                    hit_s;
   logic [WORD_SIZE-1:0]    word_s;
   logic [IDX_W-1:0]        fill_idx_s;
   logic [TAG_W-1:0]        fill_tag_s;
   logic [WAY_W-1:0]        victim_s;
   logic [WAY_W-1:0]        vptr_next_s;
   logic                    fill_s;
   logic                    clear_s;
   logic                    beat_we_s;

   assign ma_s       = |i_instr_addr[1:0];
   assign idx_s      = i_instr_addr[TAG_LSB-1:IDX_LSB];
   assign tag_s      = i_instr_addr[ADDR_WIDTH-1:TAG_LSB];
   assign off_s      = i_instr_addr[IDX_LSB-1:2];
   assign fill_idx_s = blk_addr_q[TAG_LSB-1:IDX_LSB];
   assign fill_tag_s = blk_addr_q[ADDR_WIDTH-1:TAG_LSB];
   assign hit_s      = |match_s;

   assign o_instr_addr_ma = ma_s;
   assign o_hit           = i_req & ~ma_s & hit_s & (state_q == S_IDLE);
   assign o_stall         = (state_q != S_IDLE) | (i_req & ~ma_s & ~hit_s);
   assign o_instr         = o_hit ? word_s : {WORD_SIZE{1'b0}};
   assign o_mem_req       = (state_q == S_REQ);
   assign o_mem_addr      = blk_addr_q;

   // Parallel tag compare across all ways, OR-muxing the addressed word of the matching way
   always_comb begin
      match_s = '0;
      word_s  = '0;
      for (int w = 0; w < WAY_COUNT; w++) begin
         match_s[w] = valid_q[idx_s][w] & (tag_q[idx_s][w] == tag_s);
         word_s     = word_s | ({WORD_SIZE{match_s[w]}} &
                                data_q[idx_s][w][off_s*WORD_SIZE +: WORD_SIZE]);
      end
   end

   // Victim choice: the lowest invalid way wins, otherwise the set's round-robin pointer
   always_comb begin
      victim_s = vptr_q[fill_idx_s];
      for (int w = WAY_COUNT - 1; w >= 0; w--) begin
         victim_s = valid_q[fill_idx_s][w] ? victim_s : WAY_W'(w);
      end
      vptr_next_s = (vptr_q[fill_idx_s] == WAY_W'(WAY_COUNT - 1)) ? '0
                                                                  : vptr_q[fill_idx_s] + WAY_W'(1);
   end

   // Refill FSM next-state logic and storage strobes
   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      flush_pend_d = flush_pend_q;
      blk_addr_d   = blk_addr_q;
      fill_s       = 1'b0;
      clear_s      = 1'b0;
      beat_we_s    = 1'b0;
      case (state_q)
         S_IDLE: begin
            clear_s = i_flush;
            if (i_req && !ma_s && !hit_s) begin
               blk_addr_d = {i_instr_addr[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
               state_d    = S_REQ;
            end else begin
               state_d    = S_IDLE;
            end
         end
         S_REQ: begin
            flush_pend_d = flush_pend_q | i_flush;
            if (i_mem_gnt) begin
               beat_d  = '0;
               state_d = S_RECV;
            end else begin
               state_d = S_REQ;
            end
         end
         S_RECV: begin
            flush_pend_d = flush_pend_q | i_flush;
            if (i_mem_valid) begin
               beat_we_s = 1'b1;
               beat_d    = beat_q + BEAT_W'(1);
               state_d   = (beat_q == BEAT_W'(BEATS - 1)) ? S_FILL : S_RECV;
            end else begin
               state_d   = S_RECV;
            end
         end
         S_FILL: begin
            fill_s       = 1'b1;
            clear_s      = flush_pend_q | i_flush;
            flush_pend_d = 1'b0;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state registers; a reset mid-refill abandons the refill
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_q      <= S_IDLE;
         beat_q       <= '0;
         flush_pend_q <= 1'b0;
         blk_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         flush_pend_q <= flush_pend_d;
         blk_addr_q   <= blk_addr_d;
      end
   end

   // Valid bits and victim pointers; a flush overrides the valid bit of a simultaneous fill
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         for (int s = 0; s < SET_COUNT; s++) begin
            valid_q[s] <= '0;
            vptr_q[s]  <= '0;
         end
      end else begin
         if (clear_s) begin
            for (int s = 0; s < SET_COUNT; s++) begin
               valid_q[s] <= '0;
            end
         end else if (fill_s) begin
            valid_q[fill_idx_s][victim_s] <= 1'b1;
         end
         if (fill_s) begin
            vptr_q[fill_idx_s] <= vptr_next_s;
         end
      end
   end

   // Line buffer assembly and tag/data array writes (not reset)
   always_ff @(posedge clk) begin
      if (beat_we_s) begin
         buf_q[beat_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= i_mem_data;
      end
      if (fill_s) begin
         tag_q[fill_idx_s][victim_s]  <= fill_tag_s;
         data_q[fill_idx_s][victim_s] <= buf_q;
      end
   end

endmodule

// File: tb/tb_instr_cache_sa.sv
// Self-checking bench for instr_cache_sa. A reference model tracks which blocks
// are resident in each set. Expected instruction words are derived from a
// synthetic memory image that is computed from the block address.
module tb_instr_cache_sa;

   localparam int SETS = 64;
   localparam int WAYS = 2;

   logic        clk = 1'b0;
   logic        arstn = 1'b0;
   logic [63:0] i_instr_addr = '0;
   logic        i_req = 1'b0;
   logic        i_flush = 1'b0;
   logic [31:0] o_instr;
   logic        o_hit;
   logic        o_stall;
   logic        o_instr_addr_ma;
   logic        o_mem_req;
   logic [63:0] o_mem_addr;
   logic        i_mem_gnt = 1'b0;
   logic        i_mem_valid = 1'b0;
   logic [63:0] i_mem_data = '0;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: residency per set/way plus round-robin pointers
   bit          mv [SETS][WAYS];
   logic [63:0] mt [SETS][WAYS];
   int          mp [SETS];

   always #5 clk = ~clk;

   instr_cache_sa dut (
      .clk            (clk),
      .arstn          (arstn),
      .i_instr_addr   (i_instr_addr),
      .i_req          (i_req),
      .i_flush        (i_flush),
      .o_instr        (o_instr),
      .o_hit          (o_hit),
      .o_stall        (o_stall),
      .o_instr_addr_ma(o_instr_addr_ma),
      .o_mem_req      (o_mem_req),
      .o_mem_addr     (o_mem_addr),
      .i_mem_gnt      (i_mem_gnt),
      .i_mem_valid    (i_mem_valid),
      .i_mem_data     (i_mem_data)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int set_of(input logic [63:0] a);
      return int'((a / 64) % 64);
   endfunction

   function automatic logic [63:0] tag_of(input logic [63:0] a);
      return a / 4096;
   endfunction

   function automatic int model_way(input logic [63:0] a);
      int s;
      s = set_of(a);
      for (int w = 0; w < WAYS; w++)
         if (mv[s][w] && mt[s][w] == tag_of(a)) return w;
      return -1;
   endfunction

   function automatic void model_fill(input logic [63:0] a);
      int s;
      int v;
      s = set_of(a);
      v = -1;
      for (int w = 0; w < WAYS; w++)
         if (!mv[s][w] && v < 0) v = w;
      if (v < 0) v = mp[s];
      mp[s] = (mp[s] + 1) % WAYS;
      mv[s][v] = 1'b1;
      mt[s][v] = tag_of(a);
   endfunction

   function automatic void model_clear(input bit ptrs);
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) mv[s][w] = 1'b0;
         if (ptrs) mp[s] = 0;
      end
   endfunction

   // Synthetic memory image: word k of block 0x1000 is 0x100+k
   function automatic logic [31:0] mem_word(input logic [63:0] blk, input int k);
      logic [31:0] lo;
      logic [31:0] hi;
      lo = blk[35:4];
      hi = blk[63:32];
      return (lo + 32'(k)) ^ (hi * 32'h9E37_79B9);
   endfunction

   function automatic logic [63:0] beat_data(input logic [63:0] blk, input int n);
      return {mem_word(blk, 2*n + 1), mem_word(blk, 2*n)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One fetch; on a miss, serve the refill. fl: -1 none, 0..7 flush with that beat, 8 in FILL, 9 in REQ
   task automatic fetch(input logic [63:0] a, input int fl);
      logic [63:0] blk;
      int          w;
      int          d;
      bit          ma;
      bit          flushed;
      blk = {a[63:6], 6'b0};
      ma  = |a[1:0];
      w   = model_way(a);
      flushed = 1'b0;
      i_req = 1'b1;
      i_instr_addr = a;
      @(negedge clk);
      chk("ma", o_instr_addr_ma, ma);
      chk("hit", o_hit, (!ma && w >= 0));
      chk("stall", o_stall, (!ma && w < 0));
      chk("instr", o_instr, (!ma && w >= 0) ? mem_word(blk, int'(a[5:2])) : 64'd0);
      if (ma || w >= 0) begin
         i_req = 1'b0;
         step();
         if (ma) chk("ma_noreq", o_mem_req, 1'b0);
         return;
      end
      step();
      i_req = 1'($urandom_range(0, 1));
      i_instr_addr = {$urandom, $urandom};
      if (fl == 9) begin
         i_flush = 1'b1;
         flushed = 1'b1;
      end
      d = $urandom_range(0, 2);
      for (int c = 0; c < d; c++) begin
         i_mem_valid = 1'b1;
         i_mem_data = {$urandom, $urandom};
         @(negedge clk);
         chk("req_hold", o_mem_req, 1'b1);
         step();
         i_flush = 1'b0;
      end
      i_mem_gnt = 1'b1;
      i_mem_valid = 1'($urandom_range(0, 1));
      i_mem_data = {$urandom, $urandom};
      @(negedge clk);
      chk("mem_req", o_mem_req, 1'b1);
      chk("mem_addr", o_mem_addr, blk);
      chk("stall_busy", o_stall, 1'b1);
      step();
      i_mem_gnt = 1'b0;
      i_flush = 1'b0;
      for (int n = 0; n < 8; n++) begin
         d = $urandom_range(0, 1);
         for (int c = 0; c < d; c++) begin
            i_mem_valid = 1'b0;
            i_mem_gnt = 1'($urandom_range(0, 1));
            step();
         end
         i_mem_gnt = 1'b0;
         i_mem_valid = 1'b1;
         i_mem_data = beat_data(blk, n);
         if (fl == n) begin
            i_flush = 1'b1;
            flushed = 1'b1;
         end
         @(negedge clk);
         chk("recv_noreq", o_mem_req, 1'b0);
         step();
         i_flush = 1'b0;
      end
      i_mem_valid = 1'b0;
      if (fl == 8) begin
         i_flush = 1'b1;
         flushed = 1'b1;
      end
      @(negedge clk);
      chk("stall_fill", o_stall, 1'b1);
      step();
      i_flush = 1'b0;
      model_fill(a);
      if (flushed) model_clear(1'b0);
      i_req = 1'b1;
      i_instr_addr = a;
      w = model_way(a);
      @(negedge clk);
      chk("hit_after", o_hit, (w >= 0));
      chk("instr_after", o_instr, (w >= 0) ? mem_word(blk, int'(a[5:2])) : 64'd0);
      i_req = 1'b0;
      step();
   endtask

   task automatic flush_idle();
      i_req = 1'b0;
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      model_clear(1'b0);
   endtask

   // Abort a refill with reset during beat 5, then feed late beats
   task automatic reset_mid_refill(input logic [63:0] a);
      logic [63:0] blk;
      blk = {a[63:6], 6'b0};
      i_req = 1'b1;
      i_instr_addr = a;
      @(negedge clk);
      chk("rst_pre_miss", o_hit, 1'b0);
      step();
      i_req = 1'b0;
      i_mem_gnt = 1'b1;
      step();
      i_mem_gnt = 1'b0;
      for (int n = 0; n < 5; n++) begin
         i_mem_valid = 1'b1;
         i_mem_data = beat_data(blk, n);
         step();
      end
      i_mem_data = beat_data(blk, 5);
      arstn = 1'b0;
      @(negedge clk);
      chk("rst_stall", o_stall, 1'b0);
      chk("rst_memreq", o_mem_req, 1'b0);
      step();
      arstn = 1'b1;
      for (int n = 6; n < 9; n++) begin
         i_mem_data = beat_data(blk, n % 8);
         step();
      end
      i_mem_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_memreq", o_mem_req, 1'b0);
      chk("post_rst_stall", o_stall, 1'b0);
      step();
      model_clear(1'b1);
   endtask

   initial begin
      logic [51:0] tags [4];
      logic [63:0] a;
      int          r;
      int          fl;
      model_clear(1'b1);
      repeat (3) @(posedge clk);
      #1;
      arstn = 1'b1;
      @(negedge clk);
      chk("rst_hit", o_hit, 1'b0);
      chk("rst_stall", o_stall, 1'b0);
      chk("rst_memreq", o_mem_req, 1'b0);
      step();

      fetch(64'h1000, -1);
      fetch(64'h1004, -1);
      chk("w1_const", o_instr, 64'd0);
      fetch(64'h2000, -1);
      fetch(64'h3000, -1);
      fetch(64'h2000, -1);
      fetch(64'h1000, -1);
      flush_idle();
      fetch(64'h1000, -1);
      fetch(64'h1000, 3);
      fetch(64'h1000, -1);
      fetch(64'h1002, -1);
      reset_mid_refill(64'h7000);
      fetch(64'h7000, -1);
      fetch(64'h7008, -1);

      for (int i = 0; i < 4; i++) tags[i] = {$urandom, $urandom};
      for (int it = 0; it < 200; it++) begin
         r = $urandom_range(0, 15);
         if (r == 0) begin
            flush_idle();
         end else begin
            a = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 3)), 4'($urandom),
                 (r == 1) ? 2'($urandom_range(1, 3)) : 2'b00};
            fl = ($urandom_range(0, 9) < 8) ? -1 : $urandom_range(0, 9);
            fetch(a, fl);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
